// File: rtl/mem_stage_pkg.sv
// Shared command encodings, FSM states and small decode helpers for the memory stage.
package mem_stage_pkg;

    localparam int CMD_BITS = 6;
    typedef logic [CMD_BITS-1:0] cmd_t;

    localparam cmd_t CMD_NOP = 6'h00;
    localparam cmd_t CMD_ADD = 6'h01;
    localparam cmd_t CMD_LB  = 6'h10;
    localparam cmd_t CMD_LH  = 6'h11;
    localparam cmd_t CMD_LW  = 6'h12;
    localparam cmd_t CMD_LBU = 6'h13;
    localparam cmd_t CMD_LHU = 6'h14;
    localparam cmd_t CMD_SB  = 6'h18;
    localparam cmd_t CMD_SH  = 6'h19;
    localparam cmd_t CMD_SW  = 6'h1A;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_ACCESS = 2'd1,
        MEM_DONE   = 2'd2
    } mem_state_e;

    function automatic logic is_load(cmd_t c);
        return c inside {CMD_LB, CMD_LH, CMD_LW, CMD_LBU, CMD_LHU};
    endfunction

    function automatic logic is_store(cmd_t c);
        return c inside {CMD_SB, CMD_SH, CMD_SW};
    endfunction

    function automatic logic [2:0] len_of(cmd_t c);
        case (c)
            CMD_LB, CMD_LBU, CMD_SB: return 3'd1;
            CMD_LH, CMD_LHU, CMD_SH: return 3'd2;
            CMD_LW, CMD_SW:          return 3'd4;
            default:                 return 3'd0;
        endcase
    endfunction

    function automatic logic [7:0] byte_sel(logic [31:0] d, logic [1:0] idx);
        return d[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Sign/zero extension of an assembled little-endian load result.
module mem_stage_load_extend
    import mem_stage_pkg::*;
(
    input  logic [CMD_BITS-1:0] cmd_in,
    input  logic [31:0]         raw_in,
    output logic [31:0]         ext_out
);

    always_comb begin
        ext_out = raw_in;
        case (cmd_in)
            CMD_LB:  ext_out = {{24{raw_in[7]}}, raw_in[7:0]};
            CMD_LBU: ext_out = {24'd0, raw_in[7:0]};
            CMD_LH:  ext_out = {{16{raw_in[15]}}, raw_in[15:0]};
            CMD_LHU: ext_out = {16'd0, raw_in[15:0]};
            default: ext_out = raw_in;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: sequences byte-wide RAM accesses for loads/stores and
// stalls the pipeline until the access completes; other commands pass through.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int CMD_W  = 6,
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [CMD_W-1:0]  cmdtype_in,
    input  logic [ADDR_W-1:0] mem_addr_in,
    input  logic [31:0]       store_data_in,
    input  logic [4:0]        rsd_addr_in,
    input  logic [31:0]       rsd_data_in,
    input  logic              write_rsd_in,
    input  logic              hold_in,
    input  logic              mem_gnt_in,
    input  logic [7:0]        ram_din,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    output logic              mem_req_out,
    output logic              stall_req_out,
    output logic [4:0]        rsd_addr_out,
    output logic [31:0]       rsd_data_out,
    output logic              write_rsd_out
);

    mem_state_e        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    cmd_t              cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       sdata_q, sdata_d;
    logic [4:0]        rd_q, rd_d;
    logic              wen_q, wen_d;
    logic [31:0]       result_q, result_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_wr_q, ram_wr_d;

    cmd_t        cmd_in;
    logic [1:0]  lane;
    logic [31:0] ext_result;

    assign cmd_in = cmdtype_in[CMD_BITS-1:0];
    // Byte arriving this cycle belongs to the address issued on the previous edge.
    assign lane   = cnt_q[1:0] - 2'd1;

    mem_stage_load_extend u_ext (
        .cmd_in  (cmd_q),
        .raw_in  (result_q),
        .ext_out (ext_result)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= MEM_IDLE;
            cnt_q      <= '0;
            cmd_q      <= CMD_NOP;
            addr_q     <= '0;
            sdata_q    <= '0;
            rd_q       <= '0;
            wen_q      <= 1'b0;
            result_q   <= '0;
            ram_addr_q <= '0;
            ram_dout_q <= '0;
            ram_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            rd_q       <= rd_d;
            wen_q      <= wen_d;
            result_q   <= result_d;
            ram_addr_q <= ram_addr_d;
            ram_dout_q <= ram_dout_d;
            ram_wr_q   <= ram_wr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        rd_d       = rd_q;
        wen_d      = wen_q;
        result_d   = result_q;
        ram_addr_d = ram_addr_q;
        ram_dout_d = ram_dout_q;
        ram_wr_d   = ram_wr_q;
        if (rdy_in) begin
            unique case (state_q)
                MEM_IDLE: begin
                    if ((is_load(cmd_in) || is_store(cmd_in)) && mem_gnt_in) begin
                        cmd_d      = cmd_in;
                        addr_d     = mem_addr_in;
                        sdata_d    = store_data_in;
                        rd_d       = rsd_addr_in;
                        wen_d      = write_rsd_in;
                        result_d   = '0;
                        ram_addr_d = mem_addr_in;
                        if (is_store(cmd_in)) begin
                            ram_wr_d   = 1'b1;
                            ram_dout_d = store_data_in[7:0];
                        end
                        cnt_d   = 3'd1;
                        state_d = MEM_ACCESS;
                    end
                end
                MEM_ACCESS: begin
                    if (is_load(cmd_q))
                        result_d[{lane, 3'b000} +: 8] = ram_din;
                    if (cnt_q < len_of(cmd_q)) begin
                        ram_addr_d = addr_q + {{(ADDR_W-3){1'b0}}, cnt_q};
                        if (is_store(cmd_q))
                            ram_dout_d = byte_sel(sdata_q, cnt_q[1:0]);
                        cnt_d = cnt_q + 3'd1;
                    end else begin
                        ram_wr_d = 1'b0;
                        state_d  = MEM_DONE;
                    end
                end
                MEM_DONE: begin
                    if (!hold_in)
                        state_d = MEM_IDLE;
                end
                default: state_d = MEM_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_req_out = 1'b0;
        mem_req_out   = 1'b0;
        rsd_addr_out  = rsd_addr_in;
        rsd_data_out  = rsd_data_in;
        write_rsd_out = write_rsd_in;
        unique case (state_q)
            MEM_IDLE: begin
                if (is_load(cmd_in) || is_store(cmd_in)) begin
                    stall_req_out = 1'b1;
                    mem_req_out   = 1'b1;
                    write_rsd_out = 1'b0;
                end
            end
            MEM_ACCESS: begin
                stall_req_out = 1'b1;
                mem_req_out   = 1'b1;
                rsd_addr_out  = rd_q;
                rsd_data_out  = ext_result;
                write_rsd_out = 1'b0;
            end
            MEM_DONE: begin
                rsd_addr_out  = rd_q;
                rsd_data_out  = ext_result;
                write_rsd_out = is_load(cmd_q) & wen_q;
            end
            default: ;
        endcase
        if (!rst_in) begin
            stall_req_out = 1'b0;
            mem_req_out   = 1'b0;
            rsd_addr_out  = '0;
            rsd_data_out  = '0;
            write_rsd_out = 1'b0;
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_dout = ram_dout_q;
    // A frozen pipeline must not repeat the pending byte write.
    assign ram_wr   = ram_wr_q & rdy_in;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a small byte RAM model and write log.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, write_rsd_in, hold_in, mem_gnt_in;
    logic [5:0]  cmdtype_in;
    logic [31:0] mem_addr_in, store_data_in, rsd_data_in;
    logic [4:0]  rsd_addr_in;
    logic [7:0]  ram_din;
    logic [31:0] ram_addr;
    logic [7:0]  ram_dout;
    logic        ram_wr, mem_req_out, stall_req_out, write_rsd_out;
    logic [4:0]  rsd_addr_out;
    logic [31:0] rsd_data_out;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem [0:2047];
    bit          ram_init;
    logic [31:0] wlog_a[$];
    logic [7:0]  wlog_d[$];
    logic [31:0] alog[$];

    always #5 clk_in = ~clk_in;

    mem_stage #(.CMD_W(6), .ADDR_W(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .cmdtype_in(cmdtype_in),
        .mem_addr_in(mem_addr_in), .store_data_in(store_data_in), .rsd_addr_in(rsd_addr_in),
        .rsd_data_in(rsd_data_in), .write_rsd_in(write_rsd_in), .hold_in(hold_in),
        .mem_gnt_in(mem_gnt_in), .ram_din(ram_din), .ram_addr(ram_addr), .ram_dout(ram_dout),
        .ram_wr(ram_wr), .mem_req_out(mem_req_out), .stall_req_out(stall_req_out),
        .rsd_addr_out(rsd_addr_out), .rsd_data_out(rsd_data_out), .write_rsd_out(write_rsd_out)
    );

    // Registered address in, byte out in the same cycle the address is presented.
    assign ram_din = mem[ram_addr[10:0]];

    always @(posedge clk_in) begin
        if (!ram_init) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 8'h00;
            mem[11'h100] <= 8'h78; mem[11'h101] <= 8'h56;
            mem[11'h102] <= 8'h34; mem[11'h103] <= 8'h12;
            mem[11'h200] <= 8'h80; mem[11'h201] <= 8'hFE;
            mem[11'h7FF] <= 8'h11; mem[11'h000] <= 8'h22;
            ram_init <= 1'b1;
        end else if (ram_wr) begin
            mem[ram_addr[10:0]] <= ram_dout;
            wlog_a.push_back(ram_addr);
            wlog_d.push_back(ram_dout);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic to_nop();
        cmdtype_in = CMD_NOP; write_rsd_in = 1'b0; hold_in = 1'b0; rsd_data_in = 32'h0;
        step();
    endtask

    // Issues a memory command, waits for grant, then runs until the DONE cycle.
    task automatic do_mem(input logic [5:0] cmd, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] rd, input int gnt_delay, input int rdy_low_at,
                          output int stall_cyc, output int reads, output int wen_seen);
        int done;
        cmdtype_in = cmd; mem_addr_in = addr; store_data_in = sdata; rsd_addr_in = rd;
        write_rsd_in = 1'b1; rsd_data_in = 32'hBAD0BAD0; mem_gnt_in = 1'b0; hold_in = 1'b0;
        #1;
        chk("idle_stall", 32'(stall_req_out), 32'd1);
        chk("idle_wen", 32'(write_rsd_out), 32'd0);
        for (int g = 0; g < gnt_delay; g++) begin
            step();
            chk("gnt_wait_req", 32'(mem_req_out), 32'd1);
        end
        mem_gnt_in = 1'b1;
        step();
        mem_gnt_in = 1'b0;
        alog.delete();
        stall_cyc = 0; reads = 0; wen_seen = 0; done = 0;
        for (int k = 0; k < 40; k++) begin
            rdy_in = !(rdy_low_at >= 0 && k >= rdy_low_at && k < rdy_low_at + 2);
            #1;
            if (!stall_req_out) begin
                done = 1;
                break;
            end
            stall_cyc++;
            if (write_rsd_out) wen_seen++;
            if (rdy_in) begin
                reads++;
                alog.push_back(ram_addr);
            end
            step();
        end
        rdy_in = 1'b1;
        chk("reached_done", 32'(done), 32'd1);
    endtask

    task automatic load_case(input string tag, input logic [5:0] cmd, input logic [31:0] addr,
                             input int n, input logic [31:0] exp);
        int sc, rd, ws;
        do_mem(cmd, addr, 32'h0, 5'd7, 0, -1, sc, rd, ws);
        chk({tag, "_stall_cycles"}, 32'(sc), 32'(n));
        chk({tag, "_data"}, rsd_data_out, exp);
        chk({tag, "_wen"}, 32'(write_rsd_out), 32'd1);
        to_nop();
    endtask

    initial begin
        int sc, rd, ws, base;
        rst_in = 1'b0; rdy_in = 1'b1; hold_in = 1'b0; mem_gnt_in = 1'b0;
        cmdtype_in = CMD_ADD; mem_addr_in = 32'h0; store_data_in = 32'h0;
        rsd_addr_in = 5'd3; rsd_data_in = 32'hDEADBEEF; write_rsd_in = 1'b1;
        repeat (3) step();
        chk("rst_ram_wr", 32'(ram_wr), 32'd0);
        chk("rst_ram_addr", ram_addr, 32'h0);
        chk("rst_stall", 32'(stall_req_out), 32'd0);
        chk("rst_wb_data", rsd_data_out, 32'h0);
        chk("rst_wb_wen", 32'(write_rsd_out), 32'd0);
        rst_in = 1'b1;

        // ALU passthrough
        rsd_data_in = 32'h1234; rsd_addr_in = 5'd5; write_rsd_in = 1'b1; #1;
        chk("alu_data", rsd_data_out, 32'h1234);
        chk("alu_addr", 32'(rsd_addr_out), 32'd5);
        chk("alu_wen", 32'(write_rsd_out), 32'd1);
        chk("alu_stall", 32'(stall_req_out), 32'd0);
        chk("alu_req", 32'(mem_req_out), 32'd0);
        repeat (3) step();
        chk("alu_no_writes", 32'(wlog_a.size()), 32'd0);
        to_nop();

        // LW, immediate grant
        do_mem(CMD_LW, 32'h100, 32'h0, 5'd9, 0, -1, sc, rd, ws);
        chk("lw_stall_cycles", 32'(sc), 32'd4);
        chk("lw_addr_count", 32'(alog.size()), 32'd4);
        for (int i = 0; i < 4 && i < alog.size(); i++)
            chk("lw_addr_seq", alog[i], 32'h100 + 32'(i));
        chk("lw_data", rsd_data_out, 32'h12345678);
        chk("lw_rd", 32'(rsd_addr_out), 32'd9);
        chk("lw_wen", 32'(write_rsd_out), 32'd1);
        chk("lw_wen_during", 32'(ws), 32'd0);
        to_nop();

        load_case("lb", CMD_LB, 32'h200, 1, 32'hFFFFFF80);
        load_case("lbu", CMD_LBU, 32'h200, 1, 32'h00000080);
        load_case("lh", CMD_LH, 32'h200, 2, 32'hFFFFFE80);
        load_case("lhu", CMD_LHU, 32'h200, 2, 32'h0000FE80);
        load_case("lh_pos", CMD_LH, 32'h102, 2, 32'h00001234);
        load_case("lhu_wrap", CMD_LHU, 32'hFFFFFFFF, 2, 32'h00002211);

        // SH across a 1 KiB boundary, misaligned
        base = wlog_a.size();
        do_mem(CMD_SH, 32'h3FF, 32'hAABBCCDD, 5'd4, 0, -1, sc, rd, ws);
        chk("sh_write_count", 32'(wlog_a.size() - base), 32'd2);
        if (wlog_a.size() - base == 2) begin
            chk("sh_w0_addr", wlog_a[base], 32'h3FF);
            chk("sh_w0_data", 32'(wlog_d[base]), 32'hDD);
            chk("sh_w1_addr", wlog_a[base+1], 32'h400);
            chk("sh_w1_data", 32'(wlog_d[base+1]), 32'hCC);
        end
        chk("sh_wen_during", 32'(ws), 32'd0);
        chk("sh_done_wen", 32'(write_rsd_out), 32'd0);
        chk("sh_done_ram_wr", 32'(ram_wr), 32'd0);
        to_nop();

        // LW with delayed grant, rdy gap, and downstream hold
        base = wlog_a.size();
        do_mem(CMD_LW, 32'h100, 32'h0, 5'd12, 3, 1, sc, rd, ws);
        chk("lwh_reads", 32'(rd), 32'd4);
        chk("lwh_stall_cycles", 32'(sc), 32'd6);
        for (int i = 0; i < 4 && i < alog.size(); i++)
            chk("lwh_addr_seq", alog[i], 32'h100 + 32'(i));
        chk("lwh_data", rsd_data_out, 32'h12345678);
        hold_in = 1'b1;
        for (int h = 0; h < 2; h++) begin
            step();
            chk("hold_stall", 32'(stall_req_out), 32'd0);
            chk("hold_data", rsd_data_out, 32'h12345678);
            chk("hold_wen", 32'(write_rsd_out), 32'd1);
        end
        cmdtype_in = CMD_NOP; write_rsd_in = 1'b0; rsd_data_in = 32'h55; hold_in = 1'b0;
        step();
        chk("hold_exit_data", rsd_data_out, 32'h55);
        chk("hold_exit_req", 32'(mem_req_out), 32'd0);
        chk("lwh_no_writes", 32'(wlog_a.size() - base), 32'd0);

        // Reset during the second byte of SW
        cmdtype_in = CMD_SW; mem_addr_in = 32'h300; store_data_in = 32'h01020304;
        rsd_addr_in = 5'd1; write_rsd_in = 1'b1; mem_gnt_in = 1'b1;
        step();
        mem_gnt_in = 1'b0;
        step();
        chk("sw_mid_addr", ram_addr, 32'h301);
        rst_in = 1'b0; #1;
        chk("sw_rst_ram_wr", 32'(ram_wr), 32'd0);
        chk("sw_rst_ram_addr", ram_addr, 32'h0);
        chk("sw_rst_stall", 32'(stall_req_out), 32'd0);
        chk("sw_rst_wen", 32'(write_rsd_out), 32'd0);
        cmdtype_in = CMD_NOP; write_rsd_in = 1'b1; rsd_data_in = 32'h77; #1;
        rst_in = 1'b1; #1;
        chk("sw_rst_idle_stall", 32'(stall_req_out), 32'd0);
        chk("sw_rst_idle_pass", rsd_data_out, 32'h77);
        step();
        base = wlog_a.size();
        do_mem(CMD_SW, 32'h300, 32'h01020304, 5'd1, 0, -1, sc, rd, ws);
        chk("sw_stall_cycles", 32'(sc), 32'd4);
        chk("sw_write_count", 32'(wlog_a.size() - base), 32'd4);
        for (int i = 0; i < 4 && base + i < wlog_a.size(); i++) begin
            chk("sw_addr", wlog_a[base+i], 32'h300 + 32'(i));
            chk("sw_data", 32'(wlog_d[base+i]), 32'(i + 4 - 2 * i));
        end
        to_nop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
